// File: rtl/bcd_add_sequencer.sv
// bcd_add_sequencer
//   Digit-serial packed-BCD adder controller. Operands are latched on an
//   accepted start, then one shared single-digit BCD adder walks the digits
//   LSB first with a registered decimal carry. The result feeds the
//   7-segment decode stage downstream.
//
// Ports
//   clk_i    system clock, rising edge
//   rst_i    asynchronous reset, active-high
//   start_i  add request, sampled only in IDLE or DONE
//   a_i/b_i  packed BCD operands, digit i at [4i+3:4i]
//   busy_o   high while digits are being processed
//   done_o   one-cycle pulse when sum_o/cout_o/err_o are final
//   sum_o    packed BCD result (partial digits visible while busy)
//   cout_o   decimal carry out of the top digit
//   err_o    sticky: some operand digit of this operation was > 9
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for start_i, outputs hold last result
// ADD    | processing digit idx_q, one digit per cycle
// DONE   | result final, done_o high; start_i re-accepted

module bcd_add_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   sum_o,
    output logic                  cout_o,
    output logic                  err_o
);

    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_digit;
    logic [3:0]        a_dig, b_dig;
    logic [4:0]        raw_sum;
    logic              dig_carry;
    logic [3:0]        dig_sum;
    logic              dig_bad;

    assign accept     = start_i && (state_q == S_IDLE || state_q == S_DONE);
    assign last_digit = (idx_q == LAST_IDX);

    // Single-digit BCD adder on the latched operands at idx_q.
    // (s+6)[3:0] equals s[3:0]+6 modulo 16, so a 4-bit add suffices.
    assign a_dig     = a_q[4*idx_q +: 4];
    assign b_dig     = b_q[4*idx_q +: 4];
    assign raw_sum   = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    assign dig_carry = (raw_sum > 5'd9);
    assign dig_sum   = dig_carry ? (raw_sum[3:0] + 4'd6) : raw_sum[3:0];
    assign dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_ADD;
            S_ADD:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = start_i ? S_ADD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (accept) begin
            a_d     = a_i;
            b_d     = b_i;
            sum_d   = '0;
            err_d   = 1'b0;
            cout_d  = 1'b0;
            carry_d = 1'b0;
            idx_d   = '0;
            busy_d  = 1'b1;
        end else if (state_q == S_ADD) begin
            sum_d[4*idx_q +: 4] = dig_sum;
            carry_d = dig_carry;
            if (dig_bad) err_d = 1'b1;
            if (last_digit) begin
                cout_d = dig_carry;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_add_sequencer.sv
module tb_bcd_add_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy_o, done_o, cout_o, err_o;
    logic [15:0] sum_o;

    logic        start2 = 1'b0;
    logic [7:0]  a2 = '0, b2 = '0;
    logic        busy2, done2, cout2, err2;
    logic [7:0]  sum2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_add_sequencer #(.DIGITS(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
        .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o),
        .cout_o(cout_o), .err_o(err_o)
    );

    bcd_add_sequencer #(.DIGITS(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .a_i(a2), .b_i(b2),
        .busy_o(busy2), .done_o(done2), .sum_o(sum2),
        .cout_o(cout2), .err_o(err2)
    );

    // Stimulus driver: launches one operation, scrambles the inputs after
    // acceptance, and reports the result plus observed latency/busy cycles.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          output logic [15:0] s, output logic c, output logic e,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        lat = 99; bcnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (done_o) begin
                lat = n;
                break;
            end
            if (busy_o) bcnt++;
            @(posedge clk); #1;
        end
        s = sum_o; c = cout_o; e = err_o;
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, sum_o, cout_o, err_o} !== 20'h0) begin
            errors++;
            $display("FAIL reset_dut4: got busy=%b done=%b sum=%h cout=%b err=%b, want all 0",
                     busy_o, done_o, sum_o, cout_o, err_o);
        end
        checks++;
        if ({busy2, done2, sum2, cout2, err2} !== 12'h0) begin
            errors++;
            $display("FAIL reset_dut2: got busy=%b done=%b sum=%h cout=%b err=%b, want all 0",
                     busy2, done2, sum2, cout2, err2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] s; logic c, e; int lat, bcnt;
        run_op(16'h1234, 16'h5678, s, c, e, lat, bcnt);
        checks++;
        if (s !== 16'h6912) begin errors++; $display("FAIL basic_sum: got %h want 6912", s); end
        checks++;
        if (c !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b want 0", c); end
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", e); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
        checks++;
        if (bcnt !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt); end
        @(posedge clk); #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done_o, busy_o);
        end
        checks++;
        if (sum_o !== 16'h6912) begin errors++; $display("FAIL basic_hold: got %h want 6912", sum_o); end
    endtask

    task automatic test_carry();
        logic [15:0] s; logic c, e; int lat, bcnt;
        run_op(16'h9999, 16'h0001, s, c, e, lat, bcnt);
        checks++;
        if ({s, c} !== {16'h0000, 1'b1}) begin
            errors++; $display("FAIL carry_ripple: got sum=%h cout=%b want 0000 1", s, c);
        end
        run_op(16'h9999, 16'h9999, s, c, e, lat, bcnt);
        checks++;
        if ({s, c, e} !== {16'h9998, 1'b1, 1'b0}) begin
            errors++; $display("FAIL carry_max: got sum=%h cout=%b err=%b want 9998 1 0", s, c, e);
        end
    endtask

    task automatic test_err();
        logic [15:0] s; logic c, e; int lat, bcnt;
        run_op(16'h000A, 16'h0000, s, c, e, lat, bcnt);
        checks++;
        if ({s, c, e} !== {16'h0010, 1'b0, 1'b1}) begin
            errors++; $display("FAIL err_low_digit: got sum=%h cout=%b err=%b want 0010 0 1", s, c, e);
        end
        run_op(16'h0001, 16'h0001, s, c, e, lat, bcnt);
        checks++;
        if ({s, c, e} !== {16'h0002, 1'b0, 1'b0}) begin
            errors++; $display("FAIL err_cleared: got sum=%h cout=%b err=%b want 0002 0 0", s, c, e);
        end
        run_op(16'h00F0, 16'h0000, s, c, e, lat, bcnt);
        checks++;
        if ({s, c, e} !== {16'h0150, 1'b0, 1'b1}) begin
            errors++; $display("FAIL err_sticky: got sum=%h cout=%b err=%b want 0150 0 1", s, c, e);
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int e1 = -1, e2 = -1;
        logic [15:0] s1 = '0, s2 = '0;
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (done_o) begin
                ndone++;
                if (ndone == 1) begin e1 = e; s1 = sum_o; end
                else if (ndone == 2) begin e2 = e; s2 = sum_o; end
            end
            if (e == 4) begin a = 16'h0505; b = 16'h0505; end
            if (e == 5) start = 1'b0;
        end
        checks++;
        if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
        checks++;
        if (e1 !== 4 || e2 !== 9) begin
            errors++; $display("FAIL b2b_done_edges: got %0d,%0d want 4,9", e1, e2);
        end
        checks++;
        if (s1 !== 16'h3333 || s2 !== 16'h1010) begin
            errors++; $display("FAIL b2b_sums: got %h,%h want 3333,1010", s1, s2);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        logic [15:0] s1 = '0;
        @(negedge clk);
        start = 1'b1; a = 16'h0001; b = 16'h0002;
        for (int e = 0; e < 13; e++) begin
            @(posedge clk); #1;
            if (done_o) begin ndone++; s1 = sum_o; end
            if (e == 0) begin start = 1'b0; a = 16'h4444; b = 16'h4444; end
            if (e == 1) start = 1'b1;
            if (e == 2) start = 1'b0;
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        checks++;
        if (s1 !== 16'h0003) begin errors++; $display("FAIL ignore_sum: got %h want 0003", s1); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] s; logic c, e; int lat, bcnt;
        bit saw_done = 0;
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (sum_o !== 16'h0012 || busy_o !== 1'b1) begin
            errors++; $display("FAIL abort_partial: got sum=%h busy=%b want 0012 1", sum_o, busy_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, sum_o, cout_o, err_o} !== 20'h0) begin
            errors++;
            $display("FAIL abort_async: got busy=%b done=%b sum=%h cout=%b err=%b want all 0",
                     busy_o, done_o, sum_o, cout_o, err_o);
        end
        repeat (3) begin
            @(posedge clk); #1;
            if (done_o) saw_done = 1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done pulse, want none"); end
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0005, 16'h0005, s, c, e, lat, bcnt);
        checks++;
        if ({s, c, e} !== {16'h0010, 1'b0, 1'b0} || lat !== 4) begin
            errors++;
            $display("FAIL abort_recover: got sum=%h cout=%b err=%b lat=%0d want 0010 0 0 4", s, c, e, lat);
        end
    endtask

    task automatic test_exhaustive2();
        int tot;
        logic [7:0] exp_sum;
        logic exp_cout;
        bit got_done;
        for (int i = 0; i < 100; i++) begin
            for (int j = 0; j < 100; j++) begin
                tot      = i + j;
                exp_sum  = to_bcd2(tot % 100);
                exp_cout = (tot >= 100);
                @(negedge clk);
                start2 = 1'b1; a2 = to_bcd2(i); b2 = to_bcd2(j);
                @(posedge clk); #1;
                start2 = 1'b0; a2 = 8'hFF; b2 = 8'hFF;
                got_done = 0;
                for (int n = 0; n < 10; n++) begin
                    if (done2) begin got_done = 1; break; end
                    @(posedge clk); #1;
                end
                checks++;
                if (!got_done || {sum2, cout2, err2} !== {exp_sum, exp_cout, 1'b0}) begin
                    errors++;
                    $display("FAIL exh2 %0d+%0d: got done=%b sum=%h cout=%b err=%b want sum=%h cout=%b err=0",
                             i, j, got_done, sum2, cout2, err2, exp_sum, exp_cout);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_err();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_exhaustive2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
